frame_buf_reader: RTL and testbench
===================================

// Module: frame_buf_reader
// PURPOSE
//  Read-side controller for the frame buffer data memory (DATA_WIDTH x 2^ADDR_WIDTH,
//  active-low enables, one-cycle registered read). On a start pulse it scans addresses
//  0..NUM_WORDS-1 and streams the words out over a valid/ready interface with SOF/EOF
//  markers. A 2-entry output buffer absorbs the memory read latency under backpressure.
// PARAMETERS
//  DATA_WIDTH  16  word width; matches the data memory
//  ADDR_WIDTH  3   memory address width
//  NUM_WORDS   8   words per frame, 1..2**ADDR_WIDTH
// PORTS
//  clk          in   1           system clock, rising edge
//  reset        in   1           synchronous, active-low reset
//  start        in   1           1-cycle frame request; sampled only in IDLE
//  mem_rd_en    out  1           memory read enable, active-low (0 = read issued)
//  mem_rd_addr  out  ADDR_WIDTH  memory read address
//  mem_rd_data  in   DATA_WIDTH  memory data, valid the cycle after a read issue
//  out_data     out  DATA_WIDTH  streamed word
//  out_valid    out  1           out_data valid
//  out_ready    in   1           sink accepts; transfer = out_valid & out_ready
//  out_sof      out  1           qualifies the word from address 0
//  out_eof      out  1           qualifies the word from address NUM_WORDS-1
//  busy         out  1           high in READ and DRAIN
//  done         out  1           1-cycle pulse after the EOF word transfers
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, addr=0, buffer empty, in-flight=0.
//   Outputs: mem_rd_en=1, mem_rd_addr=0, out_valid=0, out_sof=0, out_eof=0, busy=0, done=0.
//  FSM: IDLE -start-> READ; READ -last read issued-> DRAIN;
//   DRAIN -EOF word transferred-> IDLE, with done=1 for one cycle in that cycle.
//  start in READ/DRAIN is ignored, with no queuing.
//  Read issue (combinational): mem_rd_en=0 iff state==READ and
//   (count + inflight < 2, or count + inflight == 2 and a transfer occurs this cycle).
//   count = buffered words (0..2); inflight = read issued last cycle (0/1).
//  mem_rd_addr = addr register. addr increments on each issue and stops at NUM_WORDS-1.
//   There is no wrap; the next frame restarts from 0.
//  Capture: when inflight==1, mem_rd_data is written to the buffer tail at the end of
//   that cycle. Each entry carries sof/eof tag bits taken from the issued address.
//  Output: out_valid = count!=0; out_data/out_sof/out_eof come from the buffer head.
//   Head/tail pointers are 1 bit each. Capture and transfer may occur in the same cycle.
//  Latency: start high in cycle 0 -> read issue in cycle 1 -> data from memory in cycle 2
//   -> out_valid in cycle 3.
//  Throughput: with out_ready held 1, one word per cycle and no bubbles after the first.
//  Backpressure: with out_ready=0 the buffer fills to 2 and mem_rd_en stays 1.
//   No word is dropped or duplicated, and out_data stays stable while valid & !ready.
//  NUM_WORDS==1: a single word carries both SOF and EOF; FSM goes IDLE->READ->DRAIN.
//  Reset mid-frame: aborts at once to the reset state; the in-flight read is discarded.
// TESTING
//  1 Memory preloaded 0x0001..0x0008, out_ready=1, start pulse -> out_valid cycles 3..10,
//    data 1..8 in order, sof on 0x0001 only, eof on 0x0008 only, done in cycle 10.
//  2 As in 1, out_ready=0 for cycles 5..9 -> count reaches 2, mem_rd_en=1 while full,
//    out_data held stable, all 8 words delivered exactly once after ready returns.
//  3 out_ready toggling 1/0 each cycle -> 8 words in order, never more than 2 buffered.
//  4 start pulsed again in cycle 5 of a frame -> ignored; exactly 8 words, one done.
//  5 reset=0 in cycle 6 of a frame -> next cycle all outputs at reset values; a new start
//    then yields a full frame from 0x0001 with sof set.
//  6 NUM_WORDS=1 -> one word with sof=eof=1, done pulse, busy low afterwards.

Source files
------------

// File: rtl/frame_buf_reader.sv
// frame_buf_reader: streams one frame of NUM_WORDS words from a synchronous-read
// data memory onto a valid/ready interface, tagging the first word SOF and the
// last word EOF. A 2-entry buffer absorbs the one-cycle memory read latency.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   start            frame request, sampled only while idle
//   mem_rd_en        memory read enable, active-low
//   mem_rd_addr      memory read address
//   mem_rd_data      memory read data, valid the cycle after a read issue
//   out_data         streamed word
//   out_valid        out_data valid
//   out_ready        sink ready
//   out_sof/out_eof  first/last word markers
//   busy             frame in progress
//   done             one-cycle pulse in the cycle the EOF word transfers
module frame_buf_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned NUM_WORDS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    // Buffer bookkeeping: count of stored words, 1-bit head/tail pointers.
    logic [1:0]            count;
    logic                  head;
    logic                  tail;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_sof;
    logic [1:0]            buf_eof;

    // Read issued last cycle, with the tags of the address it was issued to.
    logic                  inflight;
    logic                  inflight_sof;
    logic                  inflight_eof;

    logic [1:0]            occ;
    logic                  xfer;
    logic                  issue;

    assign out_valid   = (count != 2'd0);
    assign out_data    = buf_data[head];
    assign out_sof     = out_valid & buf_sof[head];
    assign out_eof     = out_valid & buf_eof[head];
    assign busy        = (state != ST_IDLE);
    assign mem_rd_addr = addr;
    assign mem_rd_en   = ~issue;

    assign xfer = out_valid & out_ready;
    // Words already committed to the buffer: stored plus the one still in flight.
    assign occ  = count + 2'(inflight);

    // Next-state, address and issue logic.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                    addr_nxt  = '0;
                end
            end
            ST_READ: begin
                // A slot frees up this cycle if the head word transfers.
                issue = (occ < 2'd2) || ((occ == 2'd2) && xfer);
                if (issue) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        addr_nxt = addr + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && buf_eof[head]) begin
                    state_nxt = ST_IDLE;
                    addr_nxt  = '0;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            addr         <= '0;
            count        <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
            inflight_eof <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            inflight     <= issue;
            inflight_sof <= issue && (addr == '0);
            inflight_eof <= issue && (addr == LAST_ADDR);
            count        <= count + 2'(inflight) - 2'(xfer);
            if (inflight) begin
                tail <= ~tail;
            end
            if (xfer) begin
                head <= ~head;
            end
        end
    end

    // Buffer storage; tags are masked by out_valid so no reset is needed here.
    always_ff @(posedge clk) begin
        if (inflight) begin
            buf_data[tail] <= mem_rd_data;
            buf_sof[tail]  <= inflight_sof;
            buf_eof[tail]  <= inflight_eof;
        end
    end

endmodule

// File: tb/tb_frame_buf_reader.sv
module tb_frame_buf_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned NW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          out_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sof;
    logic          out_eof;
    logic          busy;
    logic          done;

    // Second instance for the single-word frame case.
    logic          start1;
    logic          ready1;
    logic          mem_rd_en1;
    logic [AW-1:0] mem_rd_addr1;
    logic [DW-1:0] mem_rd_data1;
    logic [DW-1:0] out_data1;
    logic          out_valid1;
    logic          out_sof1;
    logic          out_eof1;
    logic          busy1;
    logic          done1;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] word1;

    int checks   = 0;
    int failures = 0;

    frame_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .done(done)
    );

    frame_buf_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(ready1),
        .out_sof(out_sof1), .out_eof(out_eof1), .busy(busy1), .done(done1)
    );

    // Synchronous-read memory models.
    always @(posedge clk) begin
        if (!mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (!mem_rd_en1) mem_rd_data1 <= word1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // mode: 0 ready held high, 1 ready low in [stall_lo,stall_hi], 2 toggling, 3 random
    typedef struct {
        int mode;
        int stall_lo;
        int stall_hi;
        int restart;
        int exp_done;
        bit rand_data;
    } vec_t;

    function automatic logic ready_for(input vec_t v, input int cyc);
        case (v.mode)
            1:       return !(cyc >= v.stall_lo && cyc <= v.stall_hi);
            2:       return (cyc % 2) == 0;
            3:       return 1'($urandom);
            default: return 1'b1;
        endcase
    endfunction

    // Runs one frame on the main instance, scoring every cycle against the
    // frame rules: in-order words from mem, tags, latency, occupancy, stability.
    task automatic run_frame(input vec_t v);
        int k = 0;
        int iss = 0;
        int dones = 0;
        int done_cyc = -1;
        logic pv = 1'b0;
        logic prdy = 1'b0;
        logic [DW-1:0] pdata = '0;
        logic xfer;
        for (int i = 0; i < int'(NW); i++) mem[i] = v.rand_data ? DW'($urandom) : DW'(i + 1);
        for (int cyc = 0; cyc < 200; cyc++) begin
            start     = (cyc == 0) || (cyc == v.restart);
            out_ready = ready_for(v, cyc);
            @(negedge clk);
            xfer = out_valid && out_ready;
            chk("busy", 32'(busy), 32'(cyc >= 1 && dones == 0));
            if (cyc <= 3) chk("first_valid", 32'(out_valid), 32'(cyc == 3));
            if (v.mode == 0) chk("valid_window", 32'(out_valid), 32'(cyc >= 3 && cyc <= 2 + int'(NW)));
            if (dones > 0) chk("idle_after_done", 32'(out_valid), 32'(0));
            if (pv && !prdy) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_data", 32'(out_data), 32'(pdata));
            end
            chk("occupancy_le2", 32'((iss - k) <= 2), 32'(1));
            if ((iss - k) == 2 && !xfer) chk("full_no_read", 32'(mem_rd_en), 32'(1));
            if (!mem_rd_en) begin
                chk("rd_addr", 32'(mem_rd_addr), 32'(iss));
                iss++;
            end
            chk("done", 32'(done), 32'(xfer && k == int'(NW) - 1));
            if (xfer) begin
                chk("no_extra_word", 32'(k < int'(NW)), 32'(1));
                if (k < int'(NW)) begin
                    chk("data", 32'(out_data), 32'(mem[k]));
                    chk("sof", 32'(out_sof), 32'(k == 0));
                    chk("eof", 32'(out_eof), 32'(k == int'(NW) - 1));
                end
                k++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                if (v.exp_done >= 0) chk("done_cycle", 32'(cyc), 32'(v.exp_done));
            end
            pv = out_valid;
            prdy = out_ready;
            pdata = out_data;
            @(posedge clk);
            #1;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("done_count", 32'(dones), 32'(1));
        chk("word_count", 32'(k), 32'(NW));
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{mode: 0, stall_lo: 0, stall_hi: -1, restart: -1, exp_done: 10, rand_data: 1'b0};
        vecs[1] = '{mode: 1, stall_lo: 5, stall_hi: 9,  restart: -1, exp_done: 15, rand_data: 1'b0};
        vecs[2] = '{mode: 2, stall_lo: 0, stall_hi: -1, restart: -1, exp_done: -1, rand_data: 1'b0};
        vecs[3] = '{mode: 0, stall_lo: 0, stall_hi: -1, restart: 5,  exp_done: 10, rand_data: 1'b0};
        vecs[4] = '{mode: 3, stall_lo: 0, stall_hi: -1, restart: -1, exp_done: -1, rand_data: 1'b1};
        vecs[5] = '{mode: 3, stall_lo: 0, stall_hi: -1, restart: 7,  exp_done: -1, rand_data: 1'b1};

        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        start1 = 1'b0;
        ready1 = 1'b0;
        word1 = 16'hA5C3;
        for (int i = 0; i < int'(NW); i++) mem[i] = DW'(i + 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'(1));
        chk("rst_mem_rd_addr", 32'(mem_rd_addr), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_sof", 32'(out_sof), 32'(0));
        chk("rst_eof", 32'(out_eof), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset in cycle 6 of a frame aborts it; a fresh frame follows.
        for (int i = 0; i < int'(NW); i++) mem[i] = DW'(i + 1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            start = (cyc == 0);
            reset = (cyc != 6);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("abort_mem_rd_en", 32'(mem_rd_en), 32'(1));
        chk("abort_mem_rd_addr", 32'(mem_rd_addr), 32'(0));
        chk("abort_valid", 32'(out_valid), 32'(0));
        chk("abort_sof", 32'(out_sof), 32'(0));
        chk("abort_eof", 32'(out_eof), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        @(posedge clk);
        #1;
        run_frame(vecs[0]);

        // Single-word frame on the NUM_WORDS=1 instance.
        ready1 = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            start1 = (cyc == 0);
            @(negedge clk);
            chk("nw1_rd_en", 32'(mem_rd_en1), 32'(cyc != 1));
            if (cyc == 1) chk("nw1_rd_addr", 32'(mem_rd_addr1), 32'(0));
            chk("nw1_valid", 32'(out_valid1), 32'(cyc == 3));
            chk("nw1_busy", 32'(busy1), 32'(cyc >= 1 && cyc <= 3));
            chk("nw1_done", 32'(done1), 32'(cyc == 3));
            if (cyc == 3) begin
                chk("nw1_data", 32'(out_data1), 32'(word1));
                chk("nw1_sof", 32'(out_sof1), 32'(1));
                chk("nw1_eof", 32'(out_eof1), 32'(1));
            end
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
